// File: rtl/sysbus_mem_responder.sv
// Sysbus responder backed by a word-addressed memory.
// Serves fixed-latency line reads and BEATS-long line writes.
module sysbus_mem_responder #(
   parameter int WIDTH     = 64,
   parameter int TAG_WIDTH = 13,
   parameter int BEATS     = 8,
   parameter int LATENCY   = 4,
   parameter int MEM_WORDS = 4096
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 reqcyc,
   input  logic [WIDTH-1:0]     req,
   input  logic [TAG_WIDTH-1:0] reqtag,
   output logic                 reqack,
   output logic                 respcyc,
   output logic [WIDTH-1:0]     resp,
   output logic [TAG_WIDTH-1:0] resptag,
   input  logic                 respack
);

   localparam int AW  = $clog2(MEM_WORDS);
   localparam int BW  = $clog2(BEATS);
   localparam int LW  = $clog2(LATENCY + 1);
   localparam int DIR = TAG_WIDTH - 1;

   localparam logic [AW-1:0] LMASK    = AW'(BEATS - 1);
   localparam logic [BW-1:0] LAST     = BW'(BEATS - 1);
   localparam logic [LW-1:0] LAT_INIT = LW'(LATENCY);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RD_BURST = 2'd2,
      WR_DATA  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 reqack_q, reqack_d;
   logic                 respcyc_q, respcyc_d;
   logic [WIDTH-1:0]     resp_q, resp_d;
   logic [TAG_WIDTH-1:0] resptag_q, resptag_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic [AW-1:0]        base_q, base_d;
   logic [BW-1:0]        beat_q, beat_d;
   logic [LW-1:0]        lat_q, lat_d;

   logic [WIDTH-1:0]     mem_q [MEM_WORDS];

   logic                 accept;
   logic [BW-1:0]        nbeat;
   logic                 mem_we;
   logic [AW-1:0]        mem_waddr;
   logic [WIDTH-1:0]     mem_wdata;

   // Control registers; memory contents are deliberately not reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         reqack_q  <= 1'b0;
         respcyc_q <= 1'b0;
         resp_q    <= '1;
         resptag_q <= '0;
         tag_q     <= '0;
         base_q    <= '0;
         beat_q    <= '0;
         lat_q     <= '0;
      end else begin
         state_q   <= state_d;
         reqack_q  <= reqack_d;
         respcyc_q <= respcyc_d;
         resp_q    <= resp_d;
         resptag_q <= resptag_d;
         tag_q     <= tag_d;
         base_q    <= base_d;
         beat_q    <= beat_d;
         lat_q     <= lat_d;
      end
   end

   // Backing-store write port, one word per accepted data beat.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Next-state logic: header decode, read latency/burst, write beats.
   always_comb begin
      state_d   = state_q;
      reqack_d  = 1'b0;
      respcyc_d = respcyc_q;
      resp_d    = resp_q;
      resptag_d = resptag_q;
      tag_d     = tag_q;
      base_d    = base_q;
      beat_d    = beat_q;
      lat_d     = lat_q;
      mem_we    = 1'b0;
      mem_waddr = base_q | {{(AW-BW){1'b0}}, beat_q};
      mem_wdata = req;
      nbeat     = beat_q + 1'b1;
      // A held reqcyc is not re-accepted during its own ack cycle.
      accept    = reqcyc & ~reqack_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               reqack_d = 1'b1;
               base_d   = req[AW+2:3] & ~LMASK;
               tag_d    = reqtag;
               beat_d   = '0;
               if (reqtag[DIR]) begin
                  state_d = RD_WAIT;
                  lat_d   = LAT_INIT;
               end else begin
                  state_d = WR_DATA;
               end
            end
         end
         RD_WAIT: begin
            if (lat_q == '0) begin
               state_d   = RD_BURST;
               respcyc_d = 1'b1;
               resp_d    = mem_q[base_q];
               resptag_d = tag_q;
               beat_d    = '0;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         RD_BURST: begin
            if (respack) begin
               if (beat_q == LAST) begin
                  state_d   = IDLE;
                  respcyc_d = 1'b0;
                  resp_d    = '1;
                  beat_d    = '0;
               end else begin
                  beat_d = nbeat;
                  resp_d = mem_q[base_q | {{(AW-BW){1'b0}}, nbeat}];
               end
            end
         end
         WR_DATA: begin
            if (accept) begin
               mem_we   = 1'b1;
               reqack_d = 1'b1;
               beat_d   = nbeat;
               if (beat_q == LAST) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign reqack  = reqack_q;
   assign respcyc = respcyc_q;
   assign resp    = resp_q;
   assign resptag = resptag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder.
// Line writes, latency/burst reads, backpressure, wrap, reset abort.
module tb_sysbus_mem_responder;

   logic        clk;
   logic        reset_n;
   logic        reqcyc;
   logic [63:0] req;
   logic [12:0] reqtag;
   logic        reqack;
   logic        respcyc;
   logic [63:0] resp;
   logic [12:0] resptag;
   logic        respack;

   int errs;
   int checks;
   int ack_cnt;

   logic [63:0] pat_a [8];
   logic [63:0] pat_b [8];

   sysbus_mem_responder dut (
      .clk     (clk),
      .reset_n (reset_n),
      .reqcyc  (reqcyc),
      .req     (req),
      .reqtag  (reqtag),
      .reqack  (reqack),
      .respcyc (respcyc),
      .resp    (resp),
      .resptag (resptag),
      .respack (respack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reqack === 1'b1) ack_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [63:0] addr,
                           input logic [12:0] tag,
                           input logic [63:0] d [8]);
      int a0;
      a0 = ack_cnt;
      reqcyc = 1'b1;
      req    = addr;
      reqtag = tag;
      tick();
      chk("wr_hdr_ack", 64'(reqack), 64'd1);
      reqcyc = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         reqcyc = 1'b1;
         req    = d[i];
         tick();
         chk("wr_beat_ack", 64'(reqack), 64'd1);
         reqcyc = 1'b0;
         tick();
         chk("wr_ack_pulse", 64'(reqack), 64'd0);
      end
      chk("wr_ack_count", 64'(ack_cnt - a0), 64'd9);
   endtask

   task automatic do_read(input logic [63:0] addr,
                          input logic [12:0] tag,
                          input logic [63:0] d [8],
                          input int stall_beat,
                          input int abort_beat);
      int n;
      int a0;
      a0      = ack_cnt;
      respack = 1'b1;
      reqcyc  = 1'b1;
      req     = addr;
      reqtag  = tag;
      tick();
      chk("rd_hdr_ack", 64'(reqack), 64'd1);
      n = 0;
      do begin
         if (n == 3) reqcyc = 1'b0;
         tick();
         n++;
      end while (respcyc !== 1'b1 && n < 20);
      reqcyc = 1'b0;
      chk("rd_latency", 64'(n), 64'd5);
      for (int b = 0; b < 8; b++) begin
         if (b == abort_beat) begin
            reset_n = 1'b0;
            #1;
            chk("abort_respcyc", 64'(respcyc), 64'd0);
            chk("abort_resp", resp, '1);
            return;
         end
         chk("rd_respcyc", 64'(respcyc), 64'd1);
         chk("rd_data", resp, d[b]);
         chk("rd_tag", 64'(resptag), 64'(tag));
         if (b == stall_beat) begin
            respack = 1'b0;
            repeat (3) begin
               tick();
               chk("stall_data", resp, d[b]);
               chk("stall_cyc", 64'(respcyc), 64'd1);
            end
            respack = 1'b1;
         end
         tick();
      end
      chk("rd_end_cyc", 64'(respcyc), 64'd0);
      chk("rd_end_resp", resp, '1);
      chk("rd_ack_count", 64'(ack_cnt - a0), 64'd1);
   endtask

   initial begin
      errs    = 0;
      checks  = 0;
      ack_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         pat_a[i] = 64'(i + 1) * 64'h1111;
         pat_b[i] = 64'hCAFE_0000_0000_0000 | 64'(i);
      end

      reset_n = 1'b0;
      reqcyc  = 1'b1;
      req     = 64'h40;
      reqtag  = 13'h1000;
      respack = 1'b0;
      repeat (3) begin
         tick();
         chk("rst_reqack", 64'(reqack), 64'd0);
      end
      chk("rst_respcyc", 64'(respcyc), 64'd0);
      chk("rst_resp", resp, '1);
      chk("rst_resptag", 64'(resptag), 64'd0);
      reqcyc  = 1'b0;
      reset_n = 1'b1;
      tick();
      chk("idle_reqack", 64'(reqack), 64'd0);

      do_write(64'h40, 13'h0004, pat_a);
      do_read(64'h47, 13'h1004, pat_a, 2, -1);

      do_write(64'h8080, 13'h0011, pat_b);
      do_read(64'h80, 13'h1ABC, pat_b, -1, -1);

      do_read(64'h80, 13'h1ABC, pat_b, -1, 4);
      tick();
      tick();
      chk("held_rst_cyc", 64'(respcyc), 64'd0);
      reset_n = 1'b1;
      tick();
      do_read(64'h80, 13'h1ABC, pat_b, -1, -1);
      do_read(64'h40, 13'h1004, pat_a, -1, -1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
- Responder (memory) end of the Sysbus protocol: accepts line read and line write requests from an initiator (cache arbiter) and serves them from an internal word-addressed backing store.
- Reads return a fixed-latency, BEATS-long burst with respcyc/respack flow control. Writes accept BEATS data beats, each acknowledged with reqack.
- Serves as the DRAM stand-in for system simulation and as the reference responder for arbiter verification.

Parameters:
WIDTH, 64, data/address width of req and resp
TAG_WIDTH, 13, width of reqtag/resptag; bit 12 is the direction flag
BEATS, 8, words per line burst (power of two)
LATENCY, 4, idle cycles from read-header acceptance to first read beat (>=1)
MEM_WORDS, 4096, backing-store depth in WIDTH-bit words (power of two, multiple of BEATS)

Ports:
clk  in  1  clock, all state on posedge
reset_n  in  1  asynchronous, active-low reset
reqcyc  in  1  initiator has a valid header or write-data beat on req/reqtag
req  in  WIDTH  header: byte address; write phase: data word
reqtag  in  TAG_WIDTH  request tag; reqtag[12]=1 read, 0 write
reqack  out  1  registered one-cycle acceptance pulse per accepted reqcyc beat
respcyc  out  1  read beat valid on resp/resptag
resp  out  WIDTH  read data
resptag  out  TAG_WIDTH  tag of the read being returned
respack  in  1  initiator has consumed the current read beat

Behaviour:
- Reset (async, reset_n=0): state=IDLE, reqack=0, respcyc=0, resp='1, resptag=0, beat and latency counters=0. Backing-store contents are not reset and are undefined until written.
- Accept condition: reqcyc=1 and reqack=0 on a posedge. A reqcyc held high through the reqack cycle is not double-counted, so at most one beat is accepted every 2 cycles.
- Line index: base = req[log2(MEM_WORDS)+2:3] with the low log2(BEATS) bits cleared. Byte bits [2:0] are ignored. Addresses above the store wrap modulo MEM_WORDS.
- States:
  - IDLE: on accept, reqack<=1, latch base and reqtag.
    - reqtag[12]=1: go to RD_WAIT and load the latency counter with LATENCY.
    - reqtag[12]=0: go to WR_DATA with beat=0.
  - RD_WAIT: decrement the latency counter each cycle and ignore reqcyc. At 0, go to RD_BURST and drive respcyc=1, resp=mem[base+0], resptag=latched tag. The first beat is visible exactly LATENCY+1 cycles after the reqack cycle.
  - RD_BURST: hold the beat while respack=0. On a posedge with respcyc=1 and respack=1, advance beat and present mem[base+beat]. After beat BEATS-1 is acknowledged: respcyc<=0, resp<='1, return to IDLE. reqcyc is ignored throughout.
  - WR_DATA: on each accept, mem[base+beat]<=req, reqack<=1, beat++. After the BEATS-th beat is accepted, return to IDLE, giving BEATS+1 reqack pulses per write including the header.
- reqack is cleared on every cycle without an accept (always a single-cycle pulse).
- respack while respcyc=0 is ignored.
- A new request can be accepted in the cycle after returning to IDLE.
- Read-after-write to the same line returns the newly written data.
- Reset mid-operation aborts the burst immediately. Writes already committed remain in the store. The partial read burst is not resumed.
- Beat counter is log2(BEATS) bits; base+beat never crosses the line.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with reqcyc=1 -> reqack=0, respcyc=0, resp=all ones, resptag=0; no accept until the first posedge after release.
- Write then read: write header req=0x40, reqtag=0x0004, then data 0x1111..0x8888 -> 9 reqack pulses. Read header req=0x47, reqtag=0x1004 -> first respcyc exactly 5 cycles after reqack, resp=0x1111..0x8888 in order, resptag=0x1004 on every beat.
- Backpressure: during the read, hold respack=0 for 3 cycles on beat 2 -> resp stays 0x3333 with respcyc=1; the burst resumes at beat 3 with no skip or repeat.
- Held reqcyc: initiator keeps reqcyc=1 for 4 cycles on the read header -> exactly one reqack pulse and one read burst.
- Wrap: write a line at byte address 8*MEM_WORDS+0x80, then read at 0x80 -> identical data.
- Reset mid-read at beat 4 -> respcyc=0 asynchronously. A fresh read of the same line then returns all 8 original words.
